// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient, multiplier and result signals of fir_mac_sequencer.
// The sequencer uses the slave modport; the environment uses the master modport.
interface fir_mac_sequencer_if;
    logic [23:0] i_sample;
    logic        i_sample_valid;
    logic        o_sample_ready;
    logic        i_coef_wr;
    logic [3:0]  i_coef_addr;
    logic [15:0] i_coef_data;
    logic [23:0] o_mul_sample;
    logic [15:0] o_mul_coefficient;
    logic        o_mul_start;
    logic [39:0] i_mul_product;
    logic        i_mul_ready;
    logic [23:0] o_result;
    logic        o_result_valid;
    logic        o_busy;

    modport slave (
        input  i_sample, i_sample_valid, i_coef_wr, i_coef_addr, i_coef_data,
        input  i_mul_product, i_mul_ready,
        output o_sample_ready, o_mul_sample, o_mul_coefficient, o_mul_start,
        output o_result, o_result_valid, o_busy
    );

    modport master (
        output i_sample, i_sample_valid, i_coef_wr, i_coef_addr, i_coef_data,
        output i_mul_product, i_mul_ready,
        input  o_sample_ready, o_mul_sample, o_mul_coefficient, o_mul_start,
        input  o_result, o_result_valid, o_busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// FIR filter sequencer: one multiply-accumulate per tap through an external multiplier.
// Define FIR_MAC_SATURATE_EN to saturate the output on overflow; otherwise it wraps.
module fir_mac_sequencer #(
    parameter int TAPS = 8
) (
    input logic                i_clk,
    input logic                i_rst_n,
    fir_mac_sequencer_if.slave bus
);
    localparam int IW = $clog2(TAPS);
    localparam int KW = IW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [23:0]   x [TAPS];
    logic [15:0]   c [TAPS];
    logic [43:0]   acc;
    logic [KW-1:0] k;
    logic [IW-1:0] k_idx;
    logic          wait_first;
    logic [23:0]   sample_hold;
    logic [15:0]   coef_hold;
    logic [23:0]   result_q;
    logic          result_valid_q;
    logic [23:0]   result_next;
    logic          accept;
    logic          mac_done;
    logic          last_tap;

    assign k_idx    = k[IW-1:0];
    assign accept   = bus.i_sample_valid && (state == IDLE);
    assign mac_done = (state == WAIT) && !wait_first && bus.i_mul_ready;
    assign last_tap = (k == KW'(TAPS - 1));

`ifdef FIR_MAC_SATURATE_EN
    assign result_next = (|acc[43:39]) ? 24'hFFFFFF : acc[38:15];
`else
    logic unused_acc_msbs;
    assign unused_acc_msbs = ^acc[43:39];
    assign result_next     = acc[38:15];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // Operands come straight from the tap in ISSUE and from hold registers afterwards,
    // so a coefficient write during WAIT cannot disturb the multiply in flight.
    always_comb begin
        state_next             = state;
        bus.o_sample_ready     = 1'b0;
        bus.o_busy             = 1'b1;
        bus.o_mul_start        = 1'b0;
        bus.o_mul_sample       = sample_hold;
        bus.o_mul_coefficient  = coef_hold;
        case (state)
            IDLE: begin
                bus.o_sample_ready = 1'b1;
                bus.o_busy         = 1'b0;
                if (bus.i_sample_valid) state_next = ISSUE;
            end
            ISSUE: begin
                bus.o_mul_start       = 1'b1;
                bus.o_mul_sample      = x[k_idx];
                bus.o_mul_coefficient = c[k_idx];
                state_next            = WAIT;
            end
            WAIT: begin
                if (mac_done) state_next = last_tap ? DONE : ISSUE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
            acc            <= '0;
            k              <= '0;
            wait_first     <= 1'b0;
            sample_hold    <= '0;
            coef_hold      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (accept) begin
                for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
                x[0] <= bus.i_sample;
                acc  <= '0;
                k    <= '0;
            end
            if (state == ISSUE) begin
                sample_hold <= x[k_idx];
                coef_hold   <= c[k_idx];
                wait_first  <= 1'b1;
            end
            if (state == WAIT) wait_first <= 1'b0;
            if (mac_done) begin
                acc <= acc + {4'd0, bus.i_mul_product};
                k   <= k + 1'b1;
            end
            if (state == DONE) begin
                result_q       <= result_next;
                result_valid_q <= 1'b1;
            end
            if (bus.i_coef_wr && ({1'b0, bus.i_coef_addr} < 5'(TAPS)))
                c[bus.i_coef_addr[IW-1:0]] <= bus.i_coef_data;
        end
    end

    assign bus.o_result       = result_q;
    assign bus.o_result_valid = result_valid_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a 16-cycle multiplier model.
// Expected results assume TAPS=8 and follow FIR_MAC_SATURATE_EN if defined.
module tb_fir_mac_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_mac_sequencer_if bus ();

    fir_mac_sequencer #(.TAPS(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Multiplier: drops ready on the start edge, returns the product 16 cycles later.
    logic [4:0]  mul_cnt;
    logic [39:0] mul_prod;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt  <= 5'd0;
            mul_prod <= 40'd0;
        end else if (bus.o_mul_start) begin
            mul_cnt  <= 5'd16;
            mul_prod <= 40'(bus.o_mul_sample) * 40'(bus.o_mul_coefficient);
        end else if (mul_cnt != 5'd0) begin
            mul_cnt <= mul_cnt - 5'd1;
        end
    end
    assign bus.i_mul_ready   = (mul_cnt == 5'd0);
    assign bus.i_mul_product = mul_prod;

    int cycle       = 0;
    int start_count = 0;
    int rv_count    = 0;
    int accept_cyc[$];
    int accept_starts[$];
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (bus.o_mul_start)    start_count <= start_count + 1;
        if (bus.o_result_valid) rv_count    <= rv_count + 1;
        if (bus.i_sample_valid && bus.o_sample_ready) begin
            accept_cyc.push_back(cycle);
            accept_starts.push_back(start_count);
        end
    end

    typedef struct {
        bit          new_coefs;
        int          ca;
        int          cb;
        logic [23:0] sample;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic writeCoef(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.i_coef_wr   = 1'b1;
        bus.i_coef_addr = a;
        bus.i_coef_data = d;
        @(negedge clk);
        bus.i_coef_wr   = 1'b0;
    endtask

    task automatic setCoefs(input int ca, input int cb);
        for (int i = 0; i < 8; i++) writeCoef(4'(i), 16'h0000);
        if (ca >= 0) writeCoef(4'(ca), 16'h8000);
        if (cb >= 0) writeCoef(4'(cb), 16'h8000);
    endtask

    // Returns right after the accept edge (cycle 1 of the run).
    task automatic applyStimulus(input logic [23:0] s);
        @(negedge clk);
        bus.i_sample       = s;
        bus.i_sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_sample_valid = 1'b0;
    endtask

    task automatic waitResult(input int start_cyc, output logic [23:0] res, output int cyc,
                              output bit seen);
        cyc  = start_cyc;
        seen = 1'b0;
        res  = '0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.o_result_valid) begin
                res  = bus.o_result;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [23:0] s, input logic [23:0] exp);
        logic [23:0] res;
        int          cyc;
        bit          seen;
        applyStimulus(s);
        waitResult(1, res, cyc, seen);
        checkOutput({tag, "_seen"}, 64'(seen), 64'd1);
        checkOutput({tag, "_result"}, 64'(res), 64'(exp));
        checkOutput({tag, "_latency"}, 64'(cyc), 64'd146);
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse"}, 64'(bus.o_result_valid), 64'd0);
        checkOutput({tag, "_hold"}, 64'(bus.o_result), 64'(exp));
    endtask

    task automatic checkReset();
        checkOutput("rst_ready", 64'(bus.o_sample_ready), 64'd1);
        checkOutput("rst_busy", 64'(bus.o_busy), 64'd0);
        checkOutput("rst_start", 64'(bus.o_mul_start), 64'd0);
        checkOutput("rst_mul_sample", 64'(bus.o_mul_sample), 64'd0);
        checkOutput("rst_mul_coef", 64'(bus.o_mul_coefficient), 64'd0);
        checkOutput("rst_result", 64'(bus.o_result), 64'd0);
        checkOutput("rst_result_valid", 64'(bus.o_result_valid), 64'd0);
    endtask

    initial begin
        logic [23:0] res;
        int          cyc;
        bit          seen;
        int          base;
        int          rv_before;
        logic [23:0] ovf_exp;

`ifdef FIR_MAC_SATURATE_EN
        ovf_exp = 24'hFFFFFF;
`else
        ovf_exp = 24'h800000;
`endif
        vecs[0]  = '{1'b1, 0, -1, 24'h123456, 24'h123456};
        for (int i = 1; i < 8; i++) vecs[i] = '{1'b0, 0, -1, 24'h000000, 24'h000000};
        vecs[8]  = '{1'b1, 3, -1, 24'h000001, 24'h000000};
        vecs[9]  = '{1'b0, 3, -1, 24'h000002, 24'h000000};
        vecs[10] = '{1'b0, 3, -1, 24'h000003, 24'h000000};
        vecs[11] = '{1'b0, 3, -1, 24'h000004, 24'h000001};
        vecs[12] = '{1'b1, 0, 1, 24'hC00000, 24'hC00004};
        vecs[13] = '{1'b0, 0, 1, 24'hC00000, ovf_exp};

        bus.i_sample       = '0;
        bus.i_sample_valid = 1'b0;
        bus.i_coef_wr      = 1'b0;
        bus.i_coef_addr    = '0;
        bus.i_coef_data    = '0;
        repeat (2) @(negedge clk);
        checkReset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            if (vecs[v].new_coefs) setCoefs(vecs[v].ca, vecs[v].cb);
            runAndCheck($sformatf("vec%0d", v), vecs[v].sample, vecs[v].exp);
        end

        // Back-to-back: valid held high, expect three accepts 146 cycles apart.
        base = accept_cyc.size();
        @(negedge clk);
        bus.i_sample       = 24'h000100;
        bus.i_sample_valid = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            if (accept_cyc.size() >= base + 3) begin
                seen = 1'b1;
                break;
            end
        end
        @(negedge clk);
        bus.i_sample_valid = 1'b0;
        checkOutput("b2b_three_accepts", 64'(seen), 64'd1);
        if (seen) begin
            checkOutput("b2b_period1", 64'(accept_cyc[base+1] - accept_cyc[base]), 64'd146);
            checkOutput("b2b_period2", 64'(accept_cyc[base+2] - accept_cyc[base+1]), 64'd146);
            checkOutput("b2b_starts1", 64'(accept_starts[base+1] - accept_starts[base]), 64'd8);
            checkOutput("b2b_starts2", 64'(accept_starts[base+2] - accept_starts[base+1]), 64'd8);
        end
        waitResult(1, res, cyc, seen);
        checkOutput("b2b_last_seen", 64'(seen), 64'd1);
        checkOutput("b2b_last_latency", 64'(cyc), 64'd146);
        @(posedge clk);
        #1;
        if (accept_starts.size() >= base + 3)
            checkOutput("b2b_starts3", 64'(start_count - accept_starts[base+2]), 64'd8);

        // Reset during the WAIT of tap 3 (cycles 56..72 of the run).
        applyStimulus(24'h000055);
        repeat (59) @(posedge clk);
        rv_before = rv_count;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        checkOutput("abort_no_result", 64'(rv_count - rv_before), 64'd0);
        checkOutput("abort_ready", 64'(bus.o_sample_ready), 64'd1);
        checkOutput("abort_busy", 64'(bus.o_busy), 64'd0);
        writeCoef(4'd0, 16'h8000);
        writeCoef(4'd3, 16'h8000);
        runAndCheck("post_reset", 24'h000007, 24'h000007);

        // Coefficient written during tap 2; out-of-range address must not alias c0.
        setCoefs(-1, -1);
        runAndCheck("cw_seed", 24'h000010, 24'h000000);
        for (int i = 0; i < 6; i++) runAndCheck($sformatf("cw_fill%0d", i), 24'h000000, 24'h000000);
        writeCoef(4'd8, 16'h4000);
        applyStimulus(24'h000020);
        repeat (39) @(posedge clk);
        writeCoef(4'd7, 16'h8000);
        waitResult(41, res, cyc, seen);
        checkOutput("cw_seen", 64'(seen), 64'd1);
        checkOutput("cw_result", 64'(res), 64'h10);
        checkOutput("cw_latency", 64'(cyc), 64'd146);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
